// File: rtl/pose_sequencer_pkg.sv
// Shared types and constants for the pose record/replay sequencer.
// Widths, FSM encoding, servo default and keyboard status bit positions.
package pose_sequencer_pkg;

    localparam int SERVO_W       = 13;
    localparam int PTR_W         = 5;
    localparam int SERVO_DEFAULT = 150;

    // Bit positions of the record/play keys within the keyboard status bus
    localparam int KEY_SPACE = 8;
    localparam int KEY_ENTER = 9;

    typedef logic [SERVO_W-1:0] servo_t;
    typedef logic [PTR_W-1:0]   ptr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_HOLD = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pose_sequencer_if.sv
// Live servo bus in, sequenced servo bus out, plus key levels and status.
// master drives the live side; slave is the sequencer.
interface pose_sequencer_if;
    import pose_sequencer_pkg::*;

    servo_t i_servo0;
    servo_t i_servo1;
    servo_t i_servo2;
    servo_t i_servo3;
    logic   i_key_record;
    logic   i_key_play;
    logic   i_key_clear;

    servo_t o_servo0;
    servo_t o_servo1;
    servo_t o_servo2;
    servo_t o_servo3;
    logic   o_replaying;
    ptr_t   o_tot_state;
    ptr_t   o_current_state;
    logic   o_full;

    modport master (
        output i_servo0, i_servo1, i_servo2, i_servo3,
        output i_key_record, i_key_play, i_key_clear,
        input  o_servo0, o_servo1, o_servo2, o_servo3,
        input  o_replaying, o_tot_state, o_current_state, o_full
    );

    modport slave (
        input  i_servo0, i_servo1, i_servo2, i_servo3,
        input  i_key_record, i_key_play, i_key_clear,
        output o_servo0, o_servo1, o_servo2, o_servo3,
        output o_replaying, o_tot_state, o_current_state, o_full
    );

endinterface

// File: rtl/pose_sequencer_servo_ramp.sv
// One servo channel: step toward target by at most STEP, never overshooting.
// Purely combinational; no flow control.
module servo_ramp
    import pose_sequencer_pkg::*;
#(
    parameter int STEP = 10
) (
    input  servo_t cur,
    input  servo_t tgt,
    output servo_t nxt,
    output logic   at_target
);

    localparam logic signed [SERVO_W:0] STEP_S = (SERVO_W+1)'(STEP);

    logic signed [SERVO_W:0] diff;

    always_comb begin
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > STEP_S) begin
            nxt = cur + servo_t'(STEP);
        end else if (diff < -STEP_S) begin
            nxt = cur - servo_t'(STEP);
        end else begin
            nxt = tgt;
        end
    end

    assign at_target = (nxt == tgt);

endmodule

// File: rtl/pose_sequencer.sv
// Records four-servo poses on a key edge and replays them with rate-limited ramps and holds.
// Outputs follow live inputs combinationally when idle; replay values are registered, one tick per step.
module pose_sequencer
    import pose_sequencer_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int RAMP_STEP     = 10,
    parameter int HOLD_TICKS    = 5,
    parameter int SERVO_DEFAULT = pose_sequencer_pkg::SERVO_DEFAULT
) (
    input logic              controller_clk,
    input logic              i_rst_n,
    pose_sequencer_if.slave  bus
);

    localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              HW        = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam ptr_t            DEPTH_P   = PTR_W'(DEPTH);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_TICKS - 1);

    seq_state_t    state_q, state_nxt;
    logic          rec_q, play_q, clr_q;
    logic          rec_ev, play_ev, clr_ev;
    logic          replaying_q;
    ptr_t          tot_q, cur_q;
    logic [HW-1:0] hold_q;

    servo_t        live    [4];
    servo_t        rep_q   [4];
    servo_t        rep_nxt [4];
    servo_t        tgt     [4];
    logic [3:0]    at_tgt;

    // Not reset: content only matters below tot_q, which reset clears
    servo_t        pose_mem [4][DEPTH];

    logic has_poses, full, last_pose, hold_done, all_at;
    logic do_clear, do_record, do_start, do_step, do_hold_clr, do_hold_inc, do_advance;

    assign live[0] = bus.i_servo0;
    assign live[1] = bus.i_servo1;
    assign live[2] = bus.i_servo2;
    assign live[3] = bus.i_servo3;

    assign rec_ev  = bus.i_key_record & ~rec_q;
    assign play_ev = bus.i_key_play   & ~play_q;
    assign clr_ev  = bus.i_key_clear  & ~clr_q;

    assign has_poses = (tot_q != '0);
    assign full      = (tot_q == DEPTH_P);
    assign last_pose = ((cur_q + PTR_W'(1)) == tot_q);
    assign hold_done = (hold_q == HOLD_LAST);
    assign all_at    = &at_tgt;

    for (genvar c = 0; c < 4; c++) begin : g_ramp
        assign tgt[c] = pose_mem[c][cur_q[AW-1:0]];

        servo_ramp #(.STEP(RAMP_STEP)) u_ramp (
            .cur       (rep_q[c]),
            .tgt       (tgt[c]),
            .nxt       (rep_nxt[c]),
            .at_target (at_tgt[c])
        );
    end

    always_ff @(posedge controller_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!clr_ev && !rec_ev && play_ev && has_poses) begin
                    state_nxt = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (play_ev) begin
                    state_nxt = ST_IDLE;
                end else if (all_at) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (play_ev) begin
                    state_nxt = ST_IDLE;
                end else if (hold_done) begin
                    state_nxt = last_pose ? ST_IDLE : ST_RAMP;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath strobes; a play edge during replay suppresses every update (abort)
    always_comb begin
        do_clear    = 1'b0;
        do_record   = 1'b0;
        do_start    = 1'b0;
        do_step     = 1'b0;
        do_hold_clr = 1'b0;
        do_hold_inc = 1'b0;
        do_advance  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_ev) begin
                    do_clear = 1'b1;
                end else if (rec_ev) begin
                    do_record = ~full;
                end else if (play_ev) begin
                    do_start = has_poses;
                end
            end
            ST_RAMP: begin
                if (!play_ev) begin
                    do_step     = 1'b1;
                    do_hold_clr = all_at;
                end
            end
            ST_HOLD: begin
                if (!play_ev) begin
                    do_hold_inc = ~hold_done;
                    do_advance  = hold_done & ~last_pose;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge controller_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rec_q       <= 1'b0;
            play_q      <= 1'b0;
            clr_q       <= 1'b0;
            replaying_q <= 1'b0;
            tot_q       <= '0;
            cur_q       <= '0;
            hold_q      <= '0;
            for (int c = 0; c < 4; c++) begin
                rep_q[c] <= servo_t'(SERVO_DEFAULT);
            end
        end else begin
            rec_q       <= bus.i_key_record;
            play_q      <= bus.i_key_play;
            clr_q       <= bus.i_key_clear;
            replaying_q <= (state_nxt != ST_IDLE);

            if (do_clear) begin
                tot_q <= '0;
            end else if (do_record) begin
                tot_q <= tot_q + PTR_W'(1);
            end

            if (do_start) begin
                cur_q <= '0;
            end else if (do_advance) begin
                cur_q <= cur_q + PTR_W'(1);
            end

            if (do_hold_clr) begin
                hold_q <= '0;
            end else if (do_hold_inc) begin
                hold_q <= hold_q + HW'(1);
            end

            // Starting from the live pose avoids a jump at the start of replay
            for (int c = 0; c < 4; c++) begin
                if (do_start) begin
                    rep_q[c] <= live[c];
                end else if (do_step) begin
                    rep_q[c] <= rep_nxt[c];
                end
            end
        end
    end

    always_ff @(posedge controller_clk) begin
        if (do_record) begin
            for (int c = 0; c < 4; c++) begin
                pose_mem[c][tot_q[AW-1:0]] <= live[c];
            end
        end
    end

    assign bus.o_servo0        = replaying_q ? rep_q[0] : live[0];
    assign bus.o_servo1        = replaying_q ? rep_q[1] : live[1];
    assign bus.o_servo2        = replaying_q ? rep_q[2] : live[2];
    assign bus.o_servo3        = replaying_q ? rep_q[3] : live[3];
    assign bus.o_replaying     = replaying_q;
    assign bus.o_tot_state     = tot_q;
    assign bus.o_current_state = cur_q;
    assign bus.o_full          = full;

endmodule

// File: tb/tb_pose_sequencer.sv
// Bench for pose_sequencer: directed scenarios then random key/servo traffic,
// every tick compared against a trajectory-list reference model.
module tb_pose_sequencer;
    import pose_sequencer_pkg::*;

    localparam int DEPTH = 16;
    localparam int STEP  = 10;
    localparam int HOLD  = 5;

    logic controller_clk = 1'b0;
    logic i_rst_n        = 1'b0;

    always #5 controller_clk = ~controller_clk;

    pose_sequencer_if bus();

    pose_sequencer #(
        .DEPTH(DEPTH), .RAMP_STEP(STEP), .HOLD_TICKS(HOLD), .SERVO_DEFAULT(150)
    ) dut (
        .controller_clk (controller_clk),
        .i_rst_n        (i_rst_n),
        .bus            (bus)
    );

    typedef struct packed {
        bit rep;
        int cur;
        int v0, v1, v2, v3;
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;

    int   lv [4];
    bit   k_rec, k_play, k_clr;
    bit   p_rec, p_play, p_clr;
    int   m_tot, m_cur;
    bit   m_rep;
    int   m_val [4];
    int   poses [DEPTH][4];
    exp_t rq [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        bus.i_servo0     = servo_t'(lv[0]);
        bus.i_servo1     = servo_t'(lv[1]);
        bus.i_servo2     = servo_t'(lv[2]);
        bus.i_servo3     = servo_t'(lv[3]);
        bus.i_key_record = k_rec;
        bus.i_key_play   = k_play;
        bus.i_key_clear  = k_clr;
    endtask

    task automatic model_reset();
        m_rep = 0; m_tot = 0; m_cur = 0;
        p_rec = 0; p_play = 0; p_clr = 0;
        rq.delete();
    endtask

    // Whole replay expanded up front: one entry per tick, from the live pose
    task automatic build_replay();
        int pos [4];
        exp_t e;
        bit moving;
        rq.delete();
        pos = lv;
        e = '{1'b1, 0, pos[0], pos[1], pos[2], pos[3]};
        rq.push_back(e);
        for (int k = 0; k < m_tot; k++) begin
            do begin
                moving = 0;
                for (int c = 0; c < 4; c++) begin
                    int d = poses[k][c] - pos[c];
                    if (d > STEP) pos[c] += STEP;
                    else if (d < -STEP) pos[c] -= STEP;
                    else pos[c] = poses[k][c];
                    if (pos[c] != poses[k][c]) moving = 1;
                end
                e = '{1'b1, k, pos[0], pos[1], pos[2], pos[3]};
                rq.push_back(e);
            end while (moving);
            for (int h = 0; h < HOLD - 1; h++) rq.push_back(e);
            if (k < m_tot - 1) e = '{1'b1, k + 1, pos[0], pos[1], pos[2], pos[3]};
            else               e = '{1'b0, k, pos[0], pos[1], pos[2], pos[3]};
            rq.push_back(e);
        end
    endtask

    task automatic pop_entry();
        exp_t e;
        if (rq.size() == 0) begin
            m_rep = 0;
        end else begin
            e = rq.pop_front();
            m_rep = e.rep; m_cur = e.cur;
            m_val[0] = e.v0; m_val[1] = e.v1; m_val[2] = e.v2; m_val[3] = e.v3;
        end
    endtask

    task automatic model_edge();
        bit e_rec, e_play, e_clr;
        e_rec  = k_rec  && !p_rec;
        e_play = k_play && !p_play;
        e_clr  = k_clr  && !p_clr;
        p_rec = k_rec; p_play = k_play; p_clr = k_clr;
        if (m_rep) begin
            if (e_play) begin
                m_rep = 0;
                rq.delete();
            end else begin
                pop_entry();
            end
        end else if (e_clr) begin
            m_tot = 0;
        end else if (e_rec) begin
            if (m_tot < DEPTH) begin
                poses[m_tot] = lv;
                m_tot++;
            end
        end else if (e_play && m_tot > 0) begin
            build_replay();
            pop_entry();
        end
    endtask

    task automatic check_outputs();
        check_val("replaying", bus.o_replaying, m_rep);
        check_val("tot_state", bus.o_tot_state, m_tot);
        check_val("full", bus.o_full, m_tot == DEPTH);
        check_val("current_state", bus.o_current_state, m_cur);
        check_val("servo0", bus.o_servo0, m_rep ? m_val[0] : lv[0]);
        check_val("servo1", bus.o_servo1, m_rep ? m_val[1] : lv[1]);
        check_val("servo2", bus.o_servo2, m_rep ? m_val[2] : lv[2]);
        check_val("servo3", bus.o_servo3, m_rep ? m_val[3] : lv[3]);
    endtask

    task automatic step();
        drive();
        @(posedge controller_clk);
        model_edge();
        @(negedge controller_clk);
        check_outputs();
    endtask

    task automatic press(input int which);
        if (which == 0) k_rec = 1; else if (which == 1) k_play = 1; else k_clr = 1;
        step();
        k_rec = 0; k_play = 0; k_clr = 0;
        step();
    endtask

    task automatic set_live(input int a, input int b, input int c, input int d);
        lv[0] = a; lv[1] = b; lv[2] = c; lv[3] = d;
    endtask

    task automatic run_until_idle();
        for (int i = 0; i < 2000 && bus.o_replaying === 1'b1; i++) step();
        check_val("replay_terminates", bus.o_replaying, 0);
    endtask

    initial begin
        int rlen, max0;
        set_live(150, 150, 150, 150);
        k_rec = 0; k_play = 0; k_clr = 0;
        model_reset();
        drive();
        #12;
        check_outputs();
        @(negedge controller_clk);
        i_rst_n = 1'b1;

        // Two poses, then replay from a live pose equal to slot 0
        press(0);
        set_live(200, 100, 150, 250);
        press(0);
        check_val("t1_tot", bus.o_tot_state, 2);
        set_live(150, 150, 150, 150);
        k_play = 1;
        step();
        k_play = 0;
        rlen = (bus.o_replaying === 1'b1) ? 1 : 0;
        max0 = 0;
        for (int i = 0; i < 100 && bus.o_replaying === 1'b1; i++) begin
            step();
            if (bus.o_replaying === 1'b1) begin
                rlen++;
                if (int'(bus.o_servo0) > max0) max0 = int'(bus.o_servo0);
            end
        end
        check_val("t3_replay_len", rlen, 21);
        check_val("t3_servo0_peak", max0, 200);
        check_val("t3_final_cur", bus.o_current_state, 1);

        // Difference below one step closes in a single tick
        press(2);
        press(0);
        set_live(157, 157, 157, 157);
        press(1);
        check_val("t4_servo0", bus.o_servo0, 150);
        run_until_idle();

        // Held record stores once; overfilling stops at DEPTH
        press(2);
        k_rec = 1;
        repeat (10) step();
        k_rec = 0;
        step();
        check_val("t2_held_record", bus.o_tot_state, 1);
        press(2);
        for (int i = 0; i < DEPTH + 3; i++) begin
            set_live($urandom_range(50, 250), $urandom_range(50, 250),
                     $urandom_range(50, 250), $urandom_range(50, 250));
            press(0);
        end
        check_val("t2_tot_full", bus.o_tot_state, DEPTH);
        check_val("t2_full_flag", bus.o_full, 1);
        press(1);
        run_until_idle();

        // Abort mid-ramp, and play with nothing stored
        press(2);
        set_live(50, 50, 50, 50);
        press(0);
        set_live(250, 240, 230, 220);
        press(1);
        step();
        k_play = 1;
        step();
        check_val("t5_abort_replaying", bus.o_replaying, 0);
        check_val("t5_abort_live", bus.o_servo0, 250);
        k_play = 0;
        step();
        press(2);
        press(1);
        check_val("t5_empty_play", bus.o_replaying, 0);

        // Simultaneous clear/record/play, then asynchronous reset in HOLD
        press(0);
        k_clr = 1; k_rec = 1; k_play = 1;
        step();
        check_val("t6_same_tick_tot", bus.o_tot_state, 0);
        check_val("t6_same_tick_rep", bus.o_replaying, 0);
        k_clr = 0; k_rec = 0; k_play = 0;
        step();
        set_live(120, 130, 140, 160);
        press(0);
        press(1);
        step();
        check_val("t6_in_hold", bus.o_replaying, 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_val("t6_rst_replaying", bus.o_replaying, 0);
        check_val("t6_rst_tot", bus.o_tot_state, 0);
        check_val("t6_rst_cur", bus.o_current_state, 0);
        check_val("t6_rst_servo3", bus.o_servo3, 160);
        model_reset();
        @(negedge controller_clk);
        i_rst_n = 1'b1;

        // Random traffic
        for (int t = 0; t < 600; t++) begin
            k_rec  = ($urandom_range(0, 3) == 0);
            k_play = ($urandom_range(0, 9) == 0);
            k_clr  = ($urandom_range(0, 29) == 0);
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 3) == 0) lv[c] = $urandom_range(50, 250);
            end
            step();
        end
        k_rec = 0; k_play = 0; k_clr = 0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pose_sequencer.md
Name: pose_sequencer

Overview:
- Sits directly downstream of the keyboard-driven servo position controller and upstream of the servo PWM stage.
- Records up to DEPTH four-servo poses from the live servo bus on a record key, then replays them on a play key.
- During replay, each servo ramps toward the stored target at a bounded rate and holds for a fixed time at each pose.
- Outside replay, the live servo values pass through to the output unchanged.

Parameters:
DEPTH, 16, number of pose slots; legal range 1..31.
RAMP_STEP, 10, maximum change per controller_clk tick per servo during replay.
HOLD_TICKS, 5, ticks spent at each reached pose before advancing; minimum 1.
SERVO_DEFAULT, 150, reset value of the replay registers.

Ports:
controller_clk  in  1  slow controller tick clock; all state changes on posedge.
i_rst_n  in  1  asynchronous, active-low reset.
i_servo0..i_servo3  in  13 each  live servo positions; upstream bounds them to 50..250.
i_key_record  in  1  level from keyboard status (space).
i_key_play  in  1  level from keyboard status (enter).
i_key_clear  in  1  level; erases the recording.
o_servo0..o_servo3  out  13 each  live positions when idle, replay registers when replaying.
o_replaying  out  1  registered; 1 in states RAMP and HOLD.
o_tot_state  out  5  number of stored poses.
o_current_state  out  5  index of the pose being replayed.
o_full  out  1  combinational; 1 when o_tot_state == DEPTH.

Behaviour:
- Reset is i_rst_n, asynchronous, active-low; clock is controller_clk.
- Reset values:
  - state = IDLE, o_replaying = 0.
  - o_tot_state = 0, o_current_state = 0.
  - Replay registers = SERVO_DEFAULT.
  - Key edge-detect registers = 0.
  - Pose memory is not reset.
- Key edges: a key event is the rising edge of its level, i.e. key high this tick and low the previous tick. A held key produces exactly one event.
- Output mux is combinational: o_servoN = replaying ? rep_N : i_servoN.
- FSM states: IDLE, RAMP, HOLD.
- IDLE, events are prioritised clear > record > play; only one is acted on per tick, the others are dropped.
  - Clear: o_tot_state <= 0.
  - Record when o_tot_state < DEPTH: write {i_servo0..3} to slot o_tot_state, then o_tot_state += 1.
  - Record when full: ignored, no wrap, no overwrite.
  - Play when o_tot_state > 0:
    - rep_N <= i_servoN, so replay starts from the current live pose without a jump.
    - o_current_state <= 0.
    - state <= RAMP, o_replaying <= 1 on the same edge.
  - Play when o_tot_state = 0: ignored.
- RAMP, each tick and each channel:
  - d = target_N - rep_N, computed as 14-bit signed.
  - rep_N moves by sign(d) * min(|d|, RAMP_STEP), so it never overshoots.
  - If all four next values equal their targets: state <= HOLD, hold_cnt <= 0.
  - A pose equal to the current position therefore costs 1 RAMP tick.
- HOLD:
  - While hold_cnt < HOLD_TICKS-1: hold_cnt += 1.
  - When hold_cnt == HOLD_TICKS-1 and o_current_state < o_tot_state-1: o_current_state += 1, state <= RAMP.
  - When hold_cnt == HOLD_TICKS-1 and this is the last pose: state <= IDLE, o_replaying <= 0. Outputs revert to live; o_current_state keeps its last value.
- Play event during RAMP or HOLD: abort to IDLE on that edge; rep_N and the memory are unchanged.
- Record and clear events during replay: ignored. Edge registers still update, so a key held across the end of replay does not fire later.
- Reset mid-replay: immediate IDLE, o_tot_state = 0; pose memory content is don't-care.
- Width: positions are 13-bit unsigned; the block does not clamp (inputs are already bounded by upstream).

Decomposition:
- Shared package holds:
  - SERVO_W = 13, PTR_W = 5.
  - The FSM state encoding (IDLE = 0, RAMP = 1, HOLD = 2).
  - SERVO_DEFAULT = 150.
  - Key index constants (space = 8, enter = 9) used to slice the keyboard status bus.
- One sub-module, servo_ramp: combinational per-channel step-toward-target with outputs next value and at_target. It is instantiated 4 times.
- Pose memory is four DEPTH x 13 register arrays inside pose_sequencer.

Test Plan:
1. Reset, drive i_servo = 150, record once, change to {200,100,150,250}, record again -> o_tot_state = 2, slot0 = {150,150,150,150}, slot1 = {200,100,150,250}; o_replaying = 0, outputs track inputs.
2. Hold record high for 10 ticks -> exactly one pose stored. Record DEPTH+3 times -> o_tot_state = 16, o_full = 1, slot 15 unchanged by the extra presses.
3. Replay from test 1 with live = 150 (defaults RAMP_STEP = 10, HOLD_TICKS = 5):
   - Slot 0 reached in 1 RAMP tick, then 5 HOLD ticks.
   - o_servo3 climbs 150, 160, ... 250 over 10 ticks; o_servo0 stops at 200 after 5 ticks with no overshoot.
   - After the final hold, o_replaying falls and o_current_state = 1.
4. Live = 157, target 150 -> 1 tick to 150 (difference smaller than RAMP_STEP).
5. Press play mid-RAMP -> o_replaying = 0 on that edge and outputs equal live. Press play with o_tot_state = 0 -> no response.
6. Clear, record and play rising in the same IDLE tick -> o_tot_state = 0 and no replay. Reset asserted mid-HOLD -> all outputs at reset values asynchronously.
